// File: rtl/pulse_evt_pkg.sv
// Shared types and the round-robin selection helper for pulse_event_arbiter.
package pulse_evt_pkg;

    typedef enum logic {
        MODE_POSEDGE = 1'b0,
        MODE_PULSE   = 1'b1
    } det_mode_e;

    localparam int unsigned MAX_CH = 16;
    localparam int unsigned IDX_W  = 4;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of pend searching rr, rr+1, ... modulo n_ch.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_CH-1:0] pend,
        input logic [IDX_W-1:0]  rr,
        input int unsigned       n_ch
    );
        rr_pick_t    res;
        int unsigned k;
        res = '0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            k = (32'(rr) + i) % n_ch;
            if ((i < n_ch) && !res.found && pend[k[IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = k[IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pulse_evt_detector.sv
// Per-channel event detector: rising edge or isolated one-cycle pulse.
module pulse_evt_detector
    import pulse_evt_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_a,
    input  det_mode_e i_mode,
    output logic      o_det
);

    logic r_a1;
    logic r_a2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a1 <= 1'b0;
            r_a2 <= 1'b0;
        end else begin
            r_a1 <= i_a;
            r_a2 <= r_a1;
        end
    end

    // Pulse mode flags a 0,1,0 pattern in the cycle the input returns low.
    always_comb begin
        o_det = 1'b0;
        if (i_mode == MODE_PULSE) begin
            o_det = ~i_a & r_a1 & ~r_a2;
        end else begin
            o_det = i_a & ~r_a1;
        end
    end

endmodule

// File: rtl/pulse_event_arbiter.sv
// Multi-channel event front end: detect, latch pending, drain round-robin on valid/ready.
// Optional saturating drop counter enabled by defining PULSE_EVT_DROP_CNT_EN.
module pulse_event_arbiter
    import pulse_evt_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         a,
    input  logic [N_CH-1:0]         mode,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [$clog2(N_CH)-1:0] evt_ch,
    output logic [N_CH-1:0]         pending
`ifdef PULSE_EVT_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]        drop_cnt
`endif
);

    localparam int unsigned CH_W = $clog2(N_CH);

    logic [N_CH-1:0]   w_det;
    logic [N_CH-1:0]   r_pending;
    logic [N_CH-1:0]   w_clr;
    logic [N_CH-1:0]   w_pending_nxt;
    logic [MAX_CH-1:0] w_pend_ext;
    rr_pick_t          w_pick;
    logic              w_adv;
    logic              w_load;
    logic [CH_W-1:0]   w_gnt;
    logic [CH_W-1:0]   w_rr_nxt;
    logic              r_valid;
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   r_rr;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pulse_evt_detector u_det (
            .clk    (clk),
            .rst    (rst),
            .i_a    (a[g]),
            .i_mode (det_mode_e'(mode[g])),
            .o_det  (w_det[g])
        );
    end

    // A detection in the same edge as the clear wins, so the new event is kept.
    always_comb begin
        w_pend_ext               = '0;
        w_pend_ext[N_CH-1:0]     = r_pending;
        w_pick                   = rr_pick(w_pend_ext, IDX_W'(r_rr), N_CH);
        w_gnt                    = CH_W'(w_pick.idx);
        w_adv                    = ~r_valid | evt_ready;
        w_load                   = w_adv & w_pick.found;
        w_clr                    = '0;
        if (w_load) begin
            w_clr[w_gnt] = 1'b1;
        end
        w_pending_nxt            = (r_pending & ~w_clr) | w_det;
        w_rr_nxt                 = (32'(w_gnt) == N_CH - 1) ? '0 : w_gnt + CH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_ch      <= '0;
            r_rr      <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_adv) begin
                r_valid <= w_pick.found;
                if (w_load) begin
                    r_ch <= w_gnt;
                    r_rr <= w_rr_nxt;
                end
            end
        end
    end

    assign evt_valid = r_valid;
    assign evt_ch    = r_ch;
    assign pending   = r_pending;

`ifdef PULSE_EVT_DROP_CNT_EN
    localparam int unsigned SUM_W = CNT_W + 5;

    logic [N_CH-1:0]  w_drop;
    logic [SUM_W-1:0] w_drop_sum;
    logic [CNT_W-1:0] w_drop_cnt_nxt;
    logic [CNT_W-1:0] r_drop_cnt;

    always_comb begin
        w_drop     = w_det & r_pending & ~w_clr;
        w_drop_sum = SUM_W'(r_drop_cnt);
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_drop_sum = w_drop_sum + SUM_W'(w_drop[i]);
        end
        w_drop_cnt_nxt = (w_drop_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : w_drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_cnt_nxt;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed self-checking bench for pulse_event_arbiter (N_CH=4); drop counter checks need PULSE_EVT_DROP_CNT_EN.
module tb_pulse_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] mode;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic [3:0] pending;
`ifdef PULSE_EVT_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pulse_event_arbiter #(
        .N_CH  (4),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .mode      (mode),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .pending   (pending)
`ifdef PULSE_EVT_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        a         = '0;
        mode      = '0;
        evt_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Observed/expected vectors below are {evt_valid, evt_ch, pending}.
    task automatic test_reset;
        logic [6:0] obs;
        rst       = 1'b1;
        a         = 4'b1111;
        mode      = '0;
        evt_ready = 1'b0;
        tick();
        tick();
        obs = {evt_valid, evt_ch, pending};
        n_total++;
        if (obs !== 7'b0_00_0000) begin
            n_bad++;
            $display("FAIL reset_state got=%b want=%b", obs, 7'b0_00_0000);
        end
`ifdef PULSE_EVT_DROP_CNT_EN
        n_total++;
        if (drop_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt);
        end
`endif
        rst = 1'b0;
        a   = '0;
        for (int j = 0; j < 3; j++) begin
            tick();
            obs = {evt_valid, evt_ch, pending};
            n_total++;
            if (obs !== 7'b0_00_0000) begin
                n_bad++;
                $display("FAIL reset_quiet[%0d] got=%b want=%b", j, obs, 7'b0_00_0000);
            end
        end
    endtask

    task automatic test_posedge;
        logic [3:0] va [6];
        logic [6:0] ve [6];
        logic [6:0] obs;
        do_reset();
        va = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        ve = '{7'b0_00_0000, 7'b0_00_0001, 7'b1_00_0000, 7'b0_00_0000, 7'b0_00_0000, 7'b0_00_0000};
        for (int j = 0; j < 6; j++) begin
            a   = va[j];
            obs = {evt_valid, evt_ch, pending};
            n_total++;
            if (obs !== ve[j]) begin
                n_bad++;
                $display("FAIL posedge[%0d] got=%b want=%b", j, obs, ve[j]);
            end
            tick();
        end
    endtask

    task automatic test_pulse;
        logic [3:0] va [9];
        logic [6:0] ve [9];
        logic [6:0] obs;
        do_reset();
        mode = 4'b0010;
        va = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        ve = '{7'b0_00_0000, 7'b0_00_0000, 7'b0_00_0000, 7'b0_00_0010, 7'b1_01_0000,
               7'b0_01_0000, 7'b0_01_0000, 7'b0_01_0000, 7'b0_01_0000};
        for (int j = 0; j < 9; j++) begin
            a   = va[j];
            obs = {evt_valid, evt_ch, pending};
            n_total++;
            if (obs !== ve[j]) begin
                n_bad++;
                $display("FAIL pulse[%0d] got=%b want=%b", j, obs, ve[j]);
            end
            tick();
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] va [17];
        logic [6:0] ve [17];
        logic [6:0] obs;
        do_reset();
        va = '{4'b1101, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 4'b0000,
               4'b0000, 4'b0001, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        ve = '{7'b0_00_0000, 7'b0_00_1101, 7'b1_00_1100, 7'b1_10_1000, 7'b1_11_0000,
               7'b0_11_0000, 7'b0_11_0000, 7'b0_11_1001, 7'b1_00_1000, 7'b1_11_0000,
               7'b0_11_0000, 7'b0_11_0001, 7'b1_00_0000, 7'b0_00_0011, 7'b1_01_0001,
               7'b1_00_0000, 7'b0_00_0000};
        for (int j = 0; j < 17; j++) begin
            a   = va[j];
            obs = {evt_valid, evt_ch, pending};
            n_total++;
            if (obs !== ve[j]) begin
                n_bad++;
                $display("FAIL round_robin[%0d] got=%b want=%b", j, obs, ve[j]);
            end
            tick();
        end
    endtask

    task automatic test_stall;
        logic [3:0] va [8];
        logic       vr [8];
        logic [6:0] ve [8];
        logic [6:0] obs;
        do_reset();
        va = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        vr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ve = '{7'b0_00_0000, 7'b0_00_0100, 7'b1_10_0000, 7'b1_10_0100, 7'b1_10_0100,
               7'b1_10_0100, 7'b1_10_0000, 7'b0_10_0000};
        for (int j = 0; j < 8; j++) begin
            a         = va[j];
            evt_ready = vr[j];
            obs       = {evt_valid, evt_ch, pending};
            n_total++;
            if (obs !== ve[j]) begin
                n_bad++;
                $display("FAIL stall[%0d] got=%b want=%b", j, obs, ve[j]);
            end
            tick();
        end
`ifdef PULSE_EVT_DROP_CNT_EN
        n_total++;
        if (drop_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL stall_drop_cnt got=%0d want=1", drop_cnt);
        end
`endif
    endtask

    task automatic test_set_clear_same_edge;
        logic [3:0] va [7];
        logic       vr [7];
        logic [6:0] ve [7];
        logic [6:0] obs;
        do_reset();
        va = '{4'b0011, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        vr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ve = '{7'b0_00_0000, 7'b0_00_0011, 7'b1_00_0010, 7'b1_00_0010, 7'b1_01_0010,
               7'b1_01_0000, 7'b0_01_0000};
        for (int j = 0; j < 7; j++) begin
            a         = va[j];
            evt_ready = vr[j];
            obs       = {evt_valid, evt_ch, pending};
            n_total++;
            if (obs !== ve[j]) begin
                n_bad++;
                $display("FAIL set_clear[%0d] got=%b want=%b", j, obs, ve[j]);
            end
            tick();
        end
`ifdef PULSE_EVT_DROP_CNT_EN
        n_total++;
        if (drop_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL set_clear_drop_cnt got=%0d want=0", drop_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_transfer;
        logic [3:0] va [10];
        logic       vr [10];
        logic       vs [10];
        logic [6:0] ve [10];
        logic [6:0] obs;
        do_reset();
        va = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000};
        vr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        ve = '{7'b0_00_0000, 7'b0_00_1111, 7'b1_00_1110, 7'b0_00_0000, 7'b0_00_1111,
               7'b1_00_1110, 7'b1_01_1100, 7'b1_10_1000, 7'b1_11_0000, 7'b0_11_0000};
        for (int j = 0; j < 10; j++) begin
            a         = va[j];
            evt_ready = vr[j];
            rst       = vs[j];
            obs       = {evt_valid, evt_ch, pending};
            n_total++;
            if (obs !== ve[j]) begin
                n_bad++;
                $display("FAIL reset_mid[%0d] got=%b want=%b", j, obs, ve[j]);
            end
`ifdef PULSE_EVT_DROP_CNT_EN
            if (j == 3) begin
                n_total++;
                if (drop_cnt !== 8'd0) begin
                    n_bad++;
                    $display("FAIL reset_mid_drop_cnt got=%0d want=0", drop_cnt);
                end
            end
`endif
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        a         = '0;
        mode      = '0;
        evt_ready = 1'b0;
        test_reset();
        test_posedge();
        test_pulse();
        test_round_robin();
        test_stall();
        test_set_clear_same_edge();
        test_reset_mid_transfer();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
